// File: rtl/sfsm_flash_fetch.sv
// rtl/sfsm_flash_fetch.sv - single-byte SPI READ fetch of an sfsm state-table entry
// Drives cs/sck/dout for {CMD, BASE, addr} and returns one received byte with a valid strobe.
module sfsm_flash_fetch #(
    parameter logic [7:0]  CMD  = 8'h03,
    parameter logic [13:0] BASE = 14'h0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [9:0] addr,
    output logic       busy,
    output logic       valid,
    output logic [7:0] data,
    output logic       cs,
    output logic       sck,
    output logic       dout,
    input  logic       din
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        READ,
        DONE,
        GAP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sr_q, sr_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        ph_q, ph_d;
    logic [7:0]  rx_q, rx_d;
    logic        cs_q, cs_d;
    logic        sck_q, sck_d;
    logic        dout_q, dout_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        rx_d    = rx_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        data_d  = data_q;

        unique case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                sck_d  = 1'b0;
                dout_d = 1'b0;
                busy_d = 1'b0;
                if (req) begin
                    sr_d    = {CMD, BASE, addr};
                    cnt_d   = 6'd0;
                    ph_d    = 1'b0;
                    cs_d    = 1'b0;
                    dout_d  = sr_d[31];
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!ph_q) begin
                    ph_d  = 1'b1;
                    sck_d = 1'b1;
                end else begin
                    // Falling sck edge: present the next bit; rotate keeps every bit observable.
                    ph_d  = 1'b0;
                    sck_d = 1'b0;
                    sr_d  = {sr_q[30:0], sr_q[31]};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        dout_d  = 1'b0;
                        state_d = READ;
                    end else begin
                        dout_d = sr_d[31];
                    end
                end
            end
            READ: begin
                if (!ph_q) begin
                    ph_d  = 1'b1;
                    sck_d = 1'b1;
                end else begin
                    ph_d  = 1'b0;
                    sck_d = 1'b0;
                    rx_d  = {rx_q[6:0], din};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd39) begin
                        // Last bit lands in data on the same edge the strobe rises.
                        cs_d    = 1'b1;
                        valid_d = 1'b1;
                        data_d  = rx_d;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = GAP;
            end
            GAP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sr_q    <= 32'h0;
            cnt_q   <= 6'd0;
            ph_q    <= 1'b0;
            rx_q    <= 8'h00;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            rx_q    <= rx_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign data  = data_q;
    assign cs    = cs_q;
    assign sck   = sck_q;
    assign dout  = dout_q;

endmodule

// File: doc/sfsm_flash_fetch.md
# sfsm_flash_fetch

Serial-flash fetch controller for the sfsm core. It turns a state-table lookup request (current state plus sampled general-purpose inputs) into a single-byte SPI READ (0x03) transaction on the cs/sck/dout/din pins. It returns the fetched table byte to the FSM core with a one-cycle valid strobe. It owns the flash pins exclusively and sequences every access to the external state table.

## Interface
- `CMD`, default 8'h03: SPI read opcode shifted first.
- `BASE`, default 14'h0000: upper 14 address bits; table occupies BASE*1024 .. BASE*1024+1023.
- `clk`, input, 1: system clock; all state changes on rising edge.
- `rst`, input, 1: reset. Asynchronous, active-low; `rst`=0 forces reset state immediately.
- `req`, input, 1: fetch request. Sampled only in IDLE.
- `addr`, input, 10: table index {state[4:0], gpi[4:0]}. Captured on accepting edge.
- `busy`, output, 1: high from accepting edge until return to IDLE.
- `valid`, output, 1: one-cycle strobe; `data` is new.
- `data`, output, 8: fetched byte. Holds until next `valid`.
- `cs`, output, 1: flash chip select, active-low.
- `sck`, output, 1: SPI clock (mode 0), clk/2 while shifting.
- `dout`, output, 1: MOSI.
- `din`, input, 1: MISO.

## Operation
- States: IDLE, SHIFT, READ, DONE, GAP.
- IDLE: cs=1, sck=0, dout=0, busy=0. On edge with req=1:
  - latch shift register = {CMD, BASE, addr} (32 bits, MSB first);
  - clear bit counter (6 bits) and phase bit;
  - go to SHIFT.
- SHIFT: cs=0. Each bit spans 2 cycles.
  - Phase 0: sck=0, dout=current MSB.
  - Phase 1: sck=1, dout unchanged.
  - Edge ending phase 1: shift left, counter+1.
  - After bit 31: go to READ with counter=32.
- READ: cs=0, dout=0, same 2-cycle sck pattern.
  - Edge ending phase 1: din is shifted into an 8-bit receive register LSB-in (first bit read = data[7]).
  - After bit 39: go to DONE.
- DONE (1 cycle): cs=1, sck=0, valid=1, data=receive register, busy=1.
- GAP (1 cycle): cs=1, valid=0, busy=1. Then IDLE.
- `req` outside IDLE is ignored, not queued. Requester must hold or re-assert `req`.
- Address arithmetic: 24-bit flash address = {BASE, addr}. No carry, no wrap logic; the table never crosses the BASE window.
- `addr` changes after the accepting edge do not affect the transaction.

## Timing
- Reset values:
  - cs=1, sck=0, dout=0;
  - busy=0, valid=0, data=8'h00;
  - state=IDLE, counters 0.
- Let E0 be the edge accepting req.
  - From E0: cs=0, sck=0, dout=CMD[7]. Bit n (0..39) occupies cycles E(2n)..E(2n+2).
  - sck rises at E(2n+1) and falls at E(2n+2). dout changes only at even edges (sck falling).
  - din for read bit k (k=0..7) is sampled at edge E(66+2k), i.e. the falling sck edge ending that bit.
  - E80: DONE, valid=1, data valid, cs=1.
  - E81: GAP, valid=0.
  - E82: IDLE, busy=0. Earliest next accept is the edge E83 if req is high.
- Request-to-valid latency: 80 cycles. Minimum request period: 83 cycles. cs high at least 2 cycles between transactions.
- Reset asserted mid-transaction: outputs go to reset values asynchronously (cs=1 at once, valid never pulses). After release, data=8'h00 and the controller is in IDLE.
- Reset release: first accept possible on the first clk edge with rst=1 and req=1.
- req=1 on the E82 edge (GAP→IDLE) is not accepted. Acceptance requires state=IDLE before the edge.

## Test plan
- Basic fetch: BASE=0, addr=10'h155, flash model returns 8'hA7. dout over 32 rising sck edges = 0x03000155. valid at E80 with data=8'hA7. cs low exactly 80 cycles.
- BASE offset: BASE=14'h0001, addr=10'h3FF, flash returns 8'h3C. Address bits = 24'h0007FF. data=8'h3C.
- Back-to-back: req held high through two fetches (8'h11, 8'h22). Second cs fall occurs 83 cycles after the first. valid pulses are each 1 cycle, 83 cycles apart. cs high ≥2 cycles between them.
- Ignored request: pulse req at E10 during SHIFT with a different addr. No second transaction starts. First address is unchanged on dout.
- Reset mid-read: assert rst=0 at E70. cs=1 and sck=0 immediately, no valid pulse, data=8'h00. After release a fresh fetch returns 8'h5A correctly.
- Mode-0 check: flash model asserts an error if dout changes while sck=1 or din is sampled other than on the falling sck edge ending a read bit. Zero errors over 100 random-address fetches.
